// File: rtl/fir_mac_sched_if.sv
// Sample/coefficient/result bundle for the time-multiplexed FIR MAC scheduler.
// The master modport drives samples and coefficients; the slave modport returns results.
interface fir_mac_sched_if #(
  parameter int TAPS = 16,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 8
);
  localparam int AW = $clog2(TAPS);

  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 coef_we;
  logic                 coef_sel;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 clr_ovr;
  logic                 busy;
  logic                 out_valid;
  logic signed [OW-1:0] out_a;
  logic signed [OW-1:0] out_b;
  logic                 overrun;

  modport master (
    output in_valid, in_data, coef_we, coef_sel, coef_addr, coef_data, clr_ovr,
    input  busy, out_valid, out_a, out_b, overrun
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_sel, coef_addr, coef_data, clr_ovr,
    output busy, out_valid, out_a, out_b, overrun
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Shared-multiplier FIR: one delay line, two coefficient banks (A = 1 MHz, B = 3 MHz),
// a single MAC walked through bank A then bank B for every accepted sample.
module fir_mac_sched #(
  parameter int TAPS  = 16,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 8,
  parameter int SHIFT = 7
) (
  input  logic           clk,
  input  logic           rst,
  fir_mac_sched_if.slave bus
);
  localparam int AW  = $clog2(TAPS);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;

  typedef enum logic [1:0] {IDLE, MAC_A, MAC_B} state_t;

  state_t                state, state_nx;
  logic [AW-1:0]         k;
  logic signed [DW-1:0]  x  [TAPS];
  logic signed [CW-1:0]  ca [TAPS];
  logic signed [CW-1:0]  cb [TAPS];
  logic signed [ACW-1:0] acc, acc_nx, sh;
  logic signed [PW-1:0]  prod;
  logic signed [CW-1:0]  coef;
  logic signed [OW-1:0]  hold_a, res_sat, out_a_r, out_b_r;
  logic                  last, fits, out_valid_r, overrun_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    last     = (k == AW'(TAPS - 1));
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = MAC_A;
      MAC_A:   if (last)         state_nx = MAC_B;
      MAC_B:   if (last)         state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // One MAC per edge; saturation looks at the bits above the output sign bit.
  always_comb begin
    coef   = (state == MAC_B) ? cb[k] : ca[k];
    prod   = x[k] * coef;
    acc_nx = acc + {{AW{prod[PW-1]}}, prod};
    sh     = acc_nx >>> SHIFT;
    fits   = (sh[ACW-1:OW-1] == '0) || (sh[ACW-1:OW-1] == '1);
    if (fits)           res_sat = sh[OW-1:0];
    else if (sh[ACW-1]) res_sat = {1'b1, {(OW-1){1'b0}}};
    else                res_sat = {1'b0, {(OW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i]  <= '0;
        ca[i] <= '0;
        cb[i] <= '0;
      end
      acc         <= '0;
      k           <= '0;
      hold_a      <= '0;
      out_a_r     <= '0;
      out_b_r     <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (bus.in_valid && state != IDLE) overrun_r <= 1'b1;
      else if (bus.clr_ovr)              overrun_r <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.coef_we) begin
            if (bus.coef_sel) cb[bus.coef_addr] <= bus.coef_data;
            else              ca[bus.coef_addr] <= bus.coef_data;
          end
          if (bus.in_valid) begin
            for (int unsigned i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            x[0] <= bus.in_data;
            acc  <= '0;
            k    <= '0;
          end
        end
        MAC_A: begin
          if (last) begin
            hold_a <= res_sat;
            acc    <= '0;
            k      <= '0;
          end else begin
            acc <= acc_nx;
            k   <= k + 1'b1;
          end
        end
        MAC_B: begin
          if (last) begin
            out_a_r     <= hold_a;
            out_b_r     <= res_sat;
            out_valid_r <= 1'b1;
            acc         <= '0;
            k           <= '0;
          end else begin
            acc <= acc_nx;
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.out_valid = out_valid_r;
    bus.out_a     = out_a_r;
    bus.out_b     = out_b_r;
    bus.overrun   = overrun_r;
  end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed-vector bench for fir_mac_sched with TAPS=16, 8-bit data/coefficients, SHIFT=7.
module tb_fir_mac_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  fir_mac_sched_if #(.TAPS(16), .DW(8), .CW(8), .OW(8)) bus ();

  fir_mac_sched #(.TAPS(16), .DW(8), .CW(8), .OW(8), .SHIFT(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_sel  = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.clr_ovr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic sel, input logic [3:0] addr, input logic signed [7:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_sel  = sel;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic start_sample(input logic signed [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges until out_valid is seen, or -1 after 100 edges.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic run_sample(input logic signed [7:0] d, output int lat);
    start_sample(d);
    wait_out(lat);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.busy, bus.out_valid, bus.overrun} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.out_valid, bus.overrun});
    end
    vectors++;
    if (bus.out_a !== 8'sd0 || bus.out_b !== 8'sd0) begin
      miscompares++;
      $display("FAIL reset_outs got a=%0d b=%0d want 0 0", bus.out_a, bus.out_b);
    end
  endtask

  task automatic test_impulse_a();
    int lat;
    do_reset();
    write_coef(0, 0, 8'sd64);
    write_coef(0, 1, -8'sd128);
    start_sample(8'sd100);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL impulse_busy got=%b want=1", bus.busy);
    end
    wait_out(lat);
    vectors++;
    if (lat !== 32) begin
      miscompares++;
      $display("FAIL impulse_latency got=%0d want=32", lat);
    end
    vectors++;
    if (bus.out_a !== 8'sd50 || bus.out_b !== 8'sd0) begin
      miscompares++;
      $display("FAIL impulse_100 got a=%0d b=%0d want 50 0", bus.out_a, bus.out_b);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL impulse_idle_busy got=%b want=0", bus.busy);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== 8'sd50) begin
      miscompares++;
      $display("FAIL impulse_hold got v=%b a=%0d want 0 50", bus.out_valid, bus.out_a);
    end
    run_sample(8'sd0, lat);
    vectors++;
    if (bus.out_a !== -8'sd100) begin
      miscompares++;
      $display("FAIL impulse_0 got=%0d want=-100", bus.out_a);
    end
    // -64 >>> 7 floors to -1
    run_sample(-8'sd1, lat);
    vectors++;
    if (bus.out_a !== -8'sd1) begin
      miscompares++;
      $display("FAIL impulse_floor got=%0d want=-1", bus.out_a);
    end
  endtask

  task automatic test_bank_b();
    int lat;
    logic signed [7:0] din [3]  = '{8'sd100, 8'sd0, 8'sd0};
    logic signed [7:0] expa [3] = '{8'sd50, -8'sd100, 8'sd0};
    logic signed [7:0] expb [3] = '{8'sd0, 8'sd0, 8'sd99};
    do_reset();
    write_coef(0, 0, 8'sd64);
    write_coef(0, 1, -8'sd128);
    write_coef(1, 2, 8'sd127);
    for (int i = 0; i < 3; i++) begin
      run_sample(din[i], lat);
      vectors++;
      if (bus.out_a !== expa[i] || bus.out_b !== expb[i] || lat !== 32) begin
        miscompares++;
        $display("FAIL bank_b[%0d] got a=%0d b=%0d lat=%0d want %0d %0d 32",
                 i, bus.out_a, bus.out_b, lat, expa[i], expb[i]);
      end
      for (int j = 0; j < 7; j++) tick();
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    for (int i = 0; i < 16; i++) write_coef(0, 4'(i), 8'sd127);
    run_sample(8'sd127, lat);
    vectors++;
    if (bus.out_a !== 8'sd126) begin
      miscompares++;
      $display("FAIL sat_first got=%0d want=126", bus.out_a);
    end
    for (int i = 0; i < 15; i++) run_sample(8'sd127, lat);
    vectors++;
    if (bus.out_a !== 8'sd127 || bus.out_b !== 8'sd0) begin
      miscompares++;
      $display("FAIL sat_pos got a=%0d b=%0d want 127 0", bus.out_a, bus.out_b);
    end
    for (int i = 0; i < 16; i++) run_sample(-8'sd128, lat);
    vectors++;
    if (bus.out_a !== -8'sd128) begin
      miscompares++;
      $display("FAIL sat_neg got=%0d want=-128", bus.out_a);
    end
  endtask

  task automatic test_overrun();
    int lat;
    do_reset();
    write_coef(0, 0, 8'sd64);
    write_coef(0, 1, -8'sd128);
    start_sample(8'sd100);
    for (int i = 0; i < 9; i++) tick();
    start_sample(8'sd55);
    vectors++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set got ovr=%b busy=%b want 1 1", bus.overrun, bus.busy);
    end
    wait_out(lat);
    vectors++;
    if (bus.out_a !== 8'sd50 || lat !== 22) begin
      miscompares++;
      $display("FAIL ovr_result got a=%0d lat=%0d want 50 22", bus.out_a, lat);
    end
    run_sample(8'sd0, lat);
    vectors++;
    if (bus.out_a !== -8'sd100 || bus.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_dropped got a=%0d ovr=%b want -100 1", bus.out_a, bus.overrun);
    end
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear got=%b want=0", bus.overrun);
    end
    start_sample(8'sd0);
    for (int i = 0; i < 9; i++) tick();
    bus.clr_ovr = 1'b1;
    start_sample(8'sd1);
    bus.clr_ovr = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set_wins got=%b want=1", bus.overrun);
    end
    wait_out(lat);
  endtask

  task automatic test_coef_busy();
    int lat;
    do_reset();
    write_coef(0, 0, 8'sd64);
    start_sample(8'sd100);
    for (int i = 0; i < 4; i++) tick();
    write_coef(0, 0, 8'sd0);
    wait_out(lat);
    vectors++;
    if (bus.out_a !== 8'sd50) begin
      miscompares++;
      $display("FAIL coef_busy_seq got=%0d want=50", bus.out_a);
    end
    run_sample(8'sd100, lat);
    vectors++;
    if (bus.out_a !== 8'sd50) begin
      miscompares++;
      $display("FAIL coef_busy_readback got=%0d want=50", bus.out_a);
    end
    write_coef(0, 0, 8'sd0);
    run_sample(8'sd100, lat);
    vectors++;
    if (bus.out_a !== 8'sd0) begin
      miscompares++;
      $display("FAIL coef_idle_write got=%0d want=0", bus.out_a);
    end
    bus.coef_we   = 1'b1;
    bus.coef_sel  = 1'b0;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'sd64;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'sd100;
    tick();
    bus.coef_we   = 1'b0;
    bus.in_valid  = 1'b0;
    wait_out(lat);
    vectors++;
    if (bus.out_a !== 8'sd50 || lat !== 32) begin
      miscompares++;
      $display("FAIL coef_same_cycle got a=%0d lat=%0d want 50 32", bus.out_a, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    do_reset();
    write_coef(0, 0, 8'sd64);
    write_coef(1, 0, 8'sd64);
    run_sample(8'sd100, lat);
    vectors++;
    if (bus.out_a !== 8'sd50 || bus.out_b !== 8'sd50) begin
      miscompares++;
      $display("FAIL rstmid_pre got a=%0d b=%0d want 50 50", bus.out_a, bus.out_b);
    end
    start_sample(8'sd100);
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.out_valid, bus.overrun} !== 3'b000 || bus.out_a !== 8'sd0 || bus.out_b !== 8'sd0) begin
      miscompares++;
      $display("FAIL rstmid_async got busy=%b v=%b ovr=%b a=%0d b=%0d want all 0",
               bus.busy, bus.out_valid, bus.overrun, bus.out_a, bus.out_b);
    end
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_no_pulse got pulses=%0d busy=%b want 0 0", pulses, bus.busy);
    end
    write_coef(0, 0, 8'sd64);
    write_coef(0, 1, 8'sd64);
    run_sample(8'sd7, lat);
    vectors++;
    if (bus.out_a !== 8'sd3 || lat !== 32) begin
      miscompares++;
      $display("FAIL rstmid_clean got a=%0d lat=%0d want 3 32", bus.out_a, lat);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_impulse_a();
    test_bank_b();
    test_saturation();
    test_overrun();
    test_coef_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
